// File: rtl/alu_op_checker.sv
// alu_op_checker: recomputes expected 1-bit ALU results and keeps a registered pass/fail verdict per run
module alu_op_checker #(
    parameter int NUM_VEC = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic [2:0]       in_s,
    input  logic             in_f,
    output logic             ready,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [7:0]       op_seen,
    output logic             ff_valid,
    output logic [5:0]       ff_vec,
    output logic             done,
    output logic             all_pass
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state, state_nx;
    logic [7:0] acc_cnt;
    logic       exp_f, accept, hit, last;
    // Expected F for the presented opcode
    always_comb begin
        exp_f = 1'b0;
        case (in_s)
            3'd0: exp_f = in_a & in_b;
            3'd1: exp_f = in_a | in_b;
            3'd2: exp_f = in_a ^ in_b;
            3'd3: exp_f = ~(in_a & in_b);
            3'd4: exp_f = ~(in_a | in_b);
            3'd5: exp_f = ~(in_a ^ in_b);
            3'd6: exp_f = ~in_a;
            default: exp_f = in_b;
        endcase
    end
    // Accept qualification and the final-vector detector
    always_comb begin
        accept = in_valid && state == RUN;
        hit    = exp_f == in_f;
        last   = acc_cnt == 8'(NUM_VEC - 1);
    end
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Next-state logic: start is only honoured outside RUN
    always_comb begin
        state_nx = state;
        if (state == RUN) state_nx = (accept && last) ? DONE : RUN;
        else if (start)   state_nx = RUN;
    end
    // State-decoded outputs
    always_comb begin
        ready = state == RUN;
        done  = state == DONE;
    end
    // Scoreboard registers: cleared on reset and on a fresh run, updated per accept
    always_ff @(posedge clk) begin
        if (rst || (state != RUN && start)) begin
            acc_cnt  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            op_seen  <= '0;
            ff_valid <= 1'b0;
            ff_vec   <= '0;
            all_pass <= 1'b0;
        end else if (accept) begin
            acc_cnt       <= acc_cnt + 8'd1;
            op_seen[in_s] <= 1'b1;
            if (hit) pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
            else     fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
            if (!hit && !ff_valid) begin
                ff_valid <= 1'b1;
                ff_vec   <= {in_s, in_a, in_b, in_f};
            end
            if (last) all_pass <= hit && fail_cnt == '0 && (op_seen | (8'd1 << in_s)) == 8'hFF;
        end
    end
endmodule
